// File: rtl/mb_session_initiator.sv
// Host-side session driver for the MB ATM core: one request in, EN pulse of SETTLE cycles, sampled/classified response out.
// Latency: EN high cycles 1..SETTLE after accept, rsp_valid from SETTLE+2; response held until rsp_ready.
module mb_session_initiator #(
    parameter int         SETTLE      = 2,
    parameter int         MAX_TRIES   = 3,
    parameter logic [3:0] INIT_SALDO  = 4'hF,
    parameter logic [4:0] ECRA_OK     = 5'b00001,
    parameter logic [4:0] ECRA_PINERR = 5'b00010
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_pin,
    input  logic [4:0] req_cod,
    input  logic [3:0] req_val,
    output logic       EN,
    output logic [3:0] PIN,
    output logic [4:0] COD,
    output logic [3:0] VAL,
    output logic [3:0] SALDO,
    input  logic [3:0] VAL_OUT,
    input  logic [3:0] SALDO_OUT,
    input  logic [4:0] ECRA,
    input  logic       PAR,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_val,
    output logic [3:0] rsp_saldo,
    output logic [4:0] rsp_ecra,
    output logic [1:0] rsp_status,
    output logic       locked
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_RESP, S_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [3:0]      pin_q, val_q, bal_q, rsp_val_q, rsp_saldo_q;
    logic [4:0]      cod_q, rsp_ecra_q;
    logic [1:0]      rsp_status_q, status_d;
    logic [2:0]      fail_q;
    logic            par_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (req_valid) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (wait_q == CW'(SETTLE - 1)) state_d = S_SAMPLE;
                else                           wait_d  = wait_q + 1'b1;
            end
            S_SAMPLE: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_d = (fail_q == 3'(MAX_TRIES)) ? S_LOCKED : S_IDLE;
            end
            S_LOCKED: state_d = S_LOCKED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        EN        = (state_q == S_DRIVE);
        rsp_valid = (state_q == S_RESP);
        locked    = (state_q == S_LOCKED);
    end

    // Parity has top priority so a corrupted screen code can never be trusted.
    always_comb begin
        par_err = ((^{VAL_OUT, SALDO_OUT, ECRA}) != PAR);
        if (par_err)                  status_d = 2'b10;
        else if (ECRA == ECRA_PINERR) status_d = 2'b01;
        else if (ECRA == ECRA_OK)     status_d = 2'b00;
        else                          status_d = 2'b11;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pin_q        <= '0;
            cod_q        <= '0;
            val_q        <= '0;
            bal_q        <= INIT_SALDO;
            fail_q       <= '0;
            rsp_val_q    <= '0;
            rsp_saldo_q  <= '0;
            rsp_ecra_q   <= '0;
            rsp_status_q <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                pin_q <= req_pin;
                cod_q <= req_cod;
                val_q <= req_val;
            end
            if (state_q == S_SAMPLE) begin
                rsp_val_q    <= VAL_OUT;
                rsp_saldo_q  <= SALDO_OUT;
                rsp_ecra_q   <= ECRA;
                rsp_status_q <= status_d;
                if (status_d == 2'b00) begin
                    bal_q  <= SALDO_OUT;
                    fail_q <= '0;
                end else if (status_d == 2'b01 && fail_q != 3'(MAX_TRIES)) begin
                    fail_q <= fail_q + 1'b1;
                end
            end
        end
    end

    assign PIN        = pin_q;
    assign COD        = cod_q;
    assign VAL        = val_q;
    assign SALDO      = bal_q;
    assign rsp_val    = rsp_val_q;
    assign rsp_saldo  = rsp_saldo_q;
    assign rsp_ecra   = rsp_ecra_q;
    assign rsp_status = rsp_status_q;
endmodule

// File: tb/tb_mb_session_initiator.sv
// Directed bench for mb_session_initiator: bench plays the MB core and checks timing, classification and lockout.
module tb_mb_session_initiator;
    localparam logic [4:0] OK  = 5'b00001;
    localparam logic [4:0] PE  = 5'b00010;

    logic       CLK = 0, RST_N = 0;
    logic       req_valid = 0, req_ready;
    logic [3:0] req_pin = 0, req_val = 0;
    logic [4:0] req_cod = 0;
    logic       EN;
    logic [3:0] PIN, VAL, SALDO;
    logic [4:0] COD;
    logic [3:0] VAL_OUT = 0, SALDO_OUT = 0;
    logic [4:0] ECRA = 0;
    logic       PAR = 0;
    logic       rsp_valid, rsp_ready = 0;
    logic [3:0] rsp_val, rsp_saldo;
    logic [4:0] rsp_ecra;
    logic [1:0] rsp_status;
    logic       locked;

    int         n_tests = 0, n_fail = 0;
    logic [3:0] bal = 4'hF;

    mb_session_initiator dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pin(req_pin), .req_cod(req_cod), .req_val(req_val),
        .EN(EN), .PIN(PIN), .COD(COD), .VAL(VAL), .SALDO(SALDO),
        .VAL_OUT(VAL_OUT), .SALDO_OUT(SALDO_OUT), .ECRA(ECRA), .PAR(PAR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_val(rsp_val), .rsp_saldo(rsp_saldo), .rsp_ecra(rsp_ecra),
        .rsp_status(rsp_status), .locked(locked)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 0;
        tick();
        tick();
        RST_N = 1;
        bal = 4'hF;
        tick();
    endtask

    task automatic do_txn(input logic [3:0] pin, input logic [4:0] cod, input logic [3:0] val,
                          input logic [4:0] ecra, input logic [3:0] sout, input logic [3:0] vout,
                          input logic inv, input int hold, input logic [1:0] exp_st, input logic exp_lock);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_pin = pin; req_cod = cod; req_val = val;
        tick();
        req_valid = 0; req_pin = ~pin; req_cod = ~cod; req_val = ~val;
        chk("en_cycle1", EN, 1);
        chk("pin_out", PIN, pin);
        chk("cod_out", COD, cod);
        chk("val_out", VAL, val);
        ECRA = ecra; SALDO_OUT = sout; VAL_OUT = vout;
        PAR = (^{vout, sout, ecra}) ^ inv;
        tick();
        chk("en_cycle2", EN, 1);
        chk("pin_stable", PIN, pin);
        tick();
        chk("en_sample", EN, 0);
        chk("rsp_valid_sample", rsp_valid, 0);
        if (exp_st == 2'b00) bal = sout;
        tick();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_status", rsp_status, exp_st);
        chk("rsp_val", rsp_val, vout);
        chk("rsp_saldo", rsp_saldo, sout);
        chk("rsp_ecra", rsp_ecra, ecra);
        chk("saldo_resp", SALDO, bal);
        for (int i = 0; i < hold; i++) begin
            ECRA = ~ecra; SALDO_OUT = ~sout; VAL_OUT = ~vout; PAR = ~PAR;
            req_valid = 1;
            tick();
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_saldo", rsp_saldo, sout);
            chk("hold_rsp_status", rsp_status, exp_st);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_en", EN, 0);
        end
        req_valid = 0;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rsp_valid_after", rsp_valid, 0);
        chk("locked_after", locked, exp_lock);
        chk("req_ready_after", req_ready, !exp_lock);
    endtask

    initial begin
        logic bad;
        do_reset();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_en", EN, 0);
        chk("rst_pin", PIN, 0);
        chk("rst_cod", COD, 0);
        chk("rst_val", VAL, 0);
        chk("rst_saldo", SALDO, 4'hF);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_val, rsp_saldo, rsp_ecra, rsp_status}, 0);
        chk("rst_locked", locked, 0);

        // basic OK transaction updates the balance
        do_txn(4'hF, 5'h1F, 4'h1, OK, 4'hE, 4'h1, 0, 0, 2'b00, 0);
        chk("t1_saldo", SALDO, 4'hE);
        // unknown screen code: reject, balance untouched
        do_txn(4'h2, 5'h03, 4'h4, 5'b00100, 4'h9, 4'h2, 0, 0, 2'b11, 0);
        chk("other_saldo", SALDO, 4'hE);
        // response backpressure with changing MB outputs
        do_txn(4'h1, 5'h02, 4'h3, OK, 4'h5, 4'h6, 0, 5, 2'b00, 0);
        chk("t5_saldo", SALDO, 4'h5);

        do_reset();
        do_txn(4'h3, 5'h04, 4'h5, OK, 4'h2, 4'h7, 1, 0, 2'b10, 0);
        chk("t4_saldo", SALDO, 4'hF);

        // fail count: 2 errors, OK clears, then 2 more errors stay unlocked
        do_txn(4'h1, 5'h01, 4'h1, PE, 4'h0, 4'h0, 0, 0, 2'b01, 0);
        do_txn(4'h1, 5'h01, 4'h1, PE, 4'h0, 4'h0, 0, 0, 2'b01, 0);
        do_txn(4'h1, 5'h01, 4'h1, OK, 4'h7, 4'h1, 0, 0, 2'b00, 0);
        do_txn(4'h1, 5'h01, 4'h1, PE, 4'h0, 4'h0, 0, 0, 2'b01, 0);
        do_txn(4'h1, 5'h01, 4'h1, PE, 4'h0, 4'h0, 0, 0, 2'b01, 0);
        // parity error on a PIN-error code must not bump the count
        do_txn(4'h1, 5'h01, 4'h1, PE, 4'h0, 4'h0, 1, 0, 2'b10, 0);
        do_txn(4'h1, 5'h01, 4'h1, PE, 4'h0, 4'h0, 0, 0, 2'b01, 1);
        chk("t3_saldo", SALDO, 4'h7);

        do_reset();
        do_txn(4'h9, 5'h05, 4'h2, PE, 4'h1, 4'h1, 0, 0, 2'b01, 0);
        do_txn(4'h9, 5'h05, 4'h2, PE, 4'h1, 4'h1, 0, 0, 2'b01, 0);
        do_txn(4'h9, 5'h05, 4'h2, PE, 4'h1, 4'h1, 0, 0, 2'b01, 1);
        bad = 0;
        req_valid = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (EN || req_ready || !locked || rsp_valid) bad = 1;
        end
        req_valid = 0;
        chk("t2_locked_ignores_req", bad, 0);

        // reset in the middle of DRIVE
        do_reset();
        req_valid = 1; req_pin = 4'h6; req_cod = 5'h06; req_val = 4'h6;
        tick();
        req_valid = 0;
        chk("t6_en_before", EN, 1);
        RST_N = 0;
        #1;
        chk("t6_en_async", EN, 0);
        chk("t6_saldo", SALDO, 4'hF);
        chk("t6_pin", PIN, 0);
        tick();
        RST_N = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid || EN) bad = 1;
        end
        chk("t6_no_rsp", bad, 0);
        chk("t6_ready", req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
